forward_hazard_unit: RTL and testbench

- Parametrised successor to the EXE-stage forwarding unit of the five-stage pipelined CPU.
- Resolves RAW hazards for NUM_SRC source operands by forwarding from the EX/MEM ("pre") and MEM/WB ("ppre") stages, including link (PC+4) values.
- Never forwards x0.
- Detects load-use hazards, runs a two-state stall FSM that inserts exactly one bubble, and keeps a saturating stall counter for performance monitoring.

---
 rtl/forward_hazard_unit_pkg.sv | 15 +
 rtl/forward_hazard_unit_if.sv | 42 ++++
 rtl/forward_hazard_unit_fwd_select.sv | 63 ++++++
 rtl/forward_hazard_unit.sv | 93 +++++++++
 tb/tb_forward_hazard_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// Shared CPU definitions: writeback-select encodings and the stall FSM states
// used by the EXE-stage forwarding / hazard unit.
package cpu_pkg;

  localparam logic [1:0] REGDST_ALU = 2'b00;
  localparam logic [1:0] REGDST_MEM = 2'b01;
  localparam logic [1:0] REGDST_PC4 = 2'b10;
  localparam logic [1:0] REGDST_CMP = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Bundle of pipeline-stage inputs and forwarded outputs of the forwarding unit.
// All inputs are plain levels sampled on the rising clock edge; there is no
// valid/ready handshake, and Stall is the only back-pressure the unit exerts.
interface forward_hazard_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC-1:0]        SrcValid;
  logic [NUM_SRC*REG_AW-1:0] rs;
  logic [NUM_SRC*XLEN-1:0]   ReadData;

  logic              preMwk, preRegWr;
  logic [1:0]        preRegDst, precmp;
  logic [REG_AW-1:0] prerd;
  logic [XLEN-1:0]   preAluOutput, prePC4;

  logic              ppreMwk, ppreRegWr;
  logic [1:0]        ppreRegDst, pprecmp;
  logic [REG_AW-1:0] pprerd;
  logic [XLEN-1:0]   ppreAluOutput, pprePC4, ppreDataOut;

  logic [NUM_SRC*XLEN-1:0] RD;
  logic                    Stall;
  logic [CNT_W-1:0]        StallCount;
  cpu_pkg::state_e         DbgState;

  modport master (
    output SrcValid, rs, ReadData,
    output preMwk, preRegWr, preRegDst, prerd, precmp, preAluOutput, prePC4,
    output ppreMwk, ppreRegWr, ppreRegDst, pprerd, pprecmp, ppreAluOutput, pprePC4, ppreDataOut,
    input  RD, Stall, StallCount, DbgState
  );

  modport slave (
    input  SrcValid, rs, ReadData,
    input  preMwk, preRegWr, preRegDst, prerd, precmp, preAluOutput, prePC4,
    input  ppreMwk, ppreRegWr, ppreRegDst, pprerd, pprecmp, ppreAluOutput, pprePC4, ppreDataOut,
    output RD, Stall, StallCount, DbgState
  );
endinterface

// File: rtl/forward_hazard_unit_fwd_select.sv
// Per-operand forwarding priority mux (pre over ppre over register file) and
// load-use hazard flag for one source operand.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              src_valid_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   read_data_i,
  input  logic              pre_mwk_i,
  input  logic              pre_regwr_i,
  input  logic [1:0]        pre_regdst_i,
  input  logic [REG_AW-1:0] pre_rd_i,
  input  logic              pre_cmp_i,
  input  logic [XLEN-1:0]   pre_alu_i,
  input  logic [XLEN-1:0]   pre_pc4_i,
  input  logic              ppre_mwk_i,
  input  logic              ppre_regwr_i,
  input  logic [1:0]        ppre_regdst_i,
  input  logic [REG_AW-1:0] ppre_rd_i,
  input  logic              ppre_cmp_i,
  input  logic [XLEN-1:0]   ppre_alu_i,
  input  logic [XLEN-1:0]   ppre_pc4_i,
  input  logic [XLEN-1:0]   ppre_data_i,
  output logic [XLEN-1:0]   fwd_data_o,
  output logic              load_hazard_o
);
  logic            rs_nonzero, pre_match, ppre_match, pre_is_load;
  logic [XLEN-1:0] pre_val, ppre_val;

  assign rs_nonzero  = (rs_i != '0);
  assign pre_match   = pre_mwk_i & pre_regwr_i & (pre_rd_i == rs_i) & rs_nonzero;
  assign ppre_match  = ppre_mwk_i & ppre_regwr_i & (ppre_rd_i == rs_i) & rs_nonzero;
  assign pre_is_load = (pre_regdst_i == REGDST_MEM);

  // Load data has not returned yet in EX/MEM, so pre never supplies it.
  always_comb begin
    pre_val = '0;
    case (pre_regdst_i)
      REGDST_ALU: pre_val = pre_alu_i;
      REGDST_PC4: pre_val = pre_pc4_i;
      REGDST_CMP: pre_val = {{(XLEN-1){1'b0}}, pre_cmp_i};
      default:    pre_val = '0;
    endcase
  end

  always_comb begin
    ppre_val = '0;
    case (ppre_regdst_i)
      REGDST_ALU: ppre_val = ppre_alu_i;
      REGDST_MEM: ppre_val = ppre_data_i;
      REGDST_PC4: ppre_val = ppre_pc4_i;
      REGDST_CMP: ppre_val = {{(XLEN-1){1'b0}}, ppre_cmp_i};
      default:    ppre_val = '0;
    endcase
  end

  assign fwd_data_o    = (pre_match && !pre_is_load) ? pre_val :
                         ppre_match                  ? ppre_val : read_data_i;
  assign load_hazard_o = src_valid_i & pre_match & pre_is_load;
endmodule

// File: rtl/forward_hazard_unit.sv
// EXE-stage forwarding unit: registered forwarded operands, one-bubble
// load-use stall FSM and a saturating stall counter.
module forward_hazard_unit
  import cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input logic                 CLK,
  input logic                 Reset,
  forward_hazard_unit_if.slave bus
);
  logic [NUM_SRC*XLEN-1:0] fwd_all;
  logic [NUM_SRC-1:0]      load_hazard;
  logic                    unused_cmp;

  assign unused_cmp = ^{bus.precmp[1], bus.pprecmp[1]};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_sel (
      .src_valid_i   (bus.SrcValid[g]),
      .rs_i          (bus.rs[g*REG_AW +: REG_AW]),
      .read_data_i   (bus.ReadData[g*XLEN +: XLEN]),
      .pre_mwk_i     (bus.preMwk),
      .pre_regwr_i   (bus.preRegWr),
      .pre_regdst_i  (bus.preRegDst),
      .pre_rd_i      (bus.prerd),
      .pre_cmp_i     (bus.precmp[0]),
      .pre_alu_i     (bus.preAluOutput),
      .pre_pc4_i     (bus.prePC4),
      .ppre_mwk_i    (bus.ppreMwk),
      .ppre_regwr_i  (bus.ppreRegWr),
      .ppre_regdst_i (bus.ppreRegDst),
      .ppre_rd_i     (bus.pprerd),
      .ppre_cmp_i    (bus.pprecmp[0]),
      .ppre_alu_i    (bus.ppreAluOutput),
      .ppre_pc4_i    (bus.pprePC4),
      .ppre_data_i   (bus.ppreDataOut),
      .fwd_data_o    (fwd_all[g*XLEN +: XLEN]),
      .load_hazard_o (load_hazard[g])
    );
  end

  state_e                  state_q, state_d;
  logic [NUM_SRC*XLEN-1:0] rd_q, rd_d;
  logic                    stall_q, stall_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_RUN;
      rd_q    <= '0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
    end
  end

  // In HOLD the load has moved to ppre, so the hazard check is skipped.
  always_comb begin
    state_d = ST_RUN;
    rd_d    = rd_q;
    stall_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (|load_hazard) begin
          stall_d = 1'b1;
          state_d = ST_HOLD;
          if (cnt_q != '1) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          rd_d = fwd_all;
        end
      end
      ST_HOLD: begin
        rd_d    = fwd_all;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.RD         = rd_q;
  assign bus.Stall      = stall_q;
  assign bus.StallCount = cnt_q;
  assign bus.DbgState   = state_q;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: a default build (2 operands, 16-bit
// counter) and a 3-operand build with a 2-bit counter driven by the same vectors.
module tb_forward_hazard_unit;
  import cpu_pkg::*;

  logic CLK = 1'b0;
  logic Reset;

  typedef struct {
    bit          reset;
    logic [3:0]  sv;
    logic [4:0]  rs[4];
    logic [31:0] rdata[4];
    logic        pmwk, pwr;
    logic [1:0]  pdst, pcmp;
    logic [4:0]  prd;
    logic [31:0] palu, ppc4;
    logic        qmwk, qwr;
    logic [1:0]  qdst, qcmp;
    logic [4:0]  qrd;
    logic [31:0] qalu, qpc4, qdout;
  } stim_t;

  stim_t cur;
  int checks = 0;
  int failures = 0;

  forward_hazard_unit_if #(.XLEN(32), .NUM_SRC(2), .REG_AW(5), .CNT_W(16)) ifa ();
  forward_hazard_unit_if #(.XLEN(32), .NUM_SRC(3), .REG_AW(5), .CNT_W(2))  ifb ();

  forward_hazard_unit #(.XLEN(32), .NUM_SRC(2), .REG_AW(5), .CNT_W(16)) dut_a (
    .CLK(CLK), .Reset(Reset), .bus(ifa));
  forward_hazard_unit #(.XLEN(32), .NUM_SRC(3), .REG_AW(5), .CNT_W(2)) dut_b (
    .CLK(CLK), .Reset(Reset), .bus(ifb));

  always #5 CLK = ~CLK;

  assign Reset = cur.reset;
  assign ifa.SrcValid = cur.sv[1:0];
  assign ifa.rs       = {cur.rs[1], cur.rs[0]};
  assign ifa.ReadData = {cur.rdata[1], cur.rdata[0]};
  assign ifb.SrcValid = cur.sv[2:0];
  assign ifb.rs       = {cur.rs[2], cur.rs[1], cur.rs[0]};
  assign ifb.ReadData = {cur.rdata[2], cur.rdata[1], cur.rdata[0]};
  assign {ifa.preMwk, ifa.preRegWr, ifa.preRegDst, ifa.prerd, ifa.precmp, ifa.preAluOutput, ifa.prePC4} =
         {cur.pmwk, cur.pwr, cur.pdst, cur.prd, cur.pcmp, cur.palu, cur.ppc4};
  assign {ifb.preMwk, ifb.preRegWr, ifb.preRegDst, ifb.prerd, ifb.precmp, ifb.preAluOutput, ifb.prePC4} =
         {cur.pmwk, cur.pwr, cur.pdst, cur.prd, cur.pcmp, cur.palu, cur.ppc4};
  assign {ifa.ppreMwk, ifa.ppreRegWr, ifa.ppreRegDst, ifa.pprerd, ifa.pprecmp, ifa.ppreAluOutput, ifa.pprePC4, ifa.ppreDataOut} =
         {cur.qmwk, cur.qwr, cur.qdst, cur.qrd, cur.qcmp, cur.qalu, cur.qpc4, cur.qdout};
  assign {ifb.ppreMwk, ifb.ppreRegWr, ifb.ppreRegDst, ifb.pprerd, ifb.pprecmp, ifb.ppreAluOutput, ifb.pprePC4, ifb.ppreDataOut} =
         {cur.qmwk, cur.qwr, cur.qdst, cur.qrd, cur.qcmp, cur.qalu, cur.qpc4, cur.qdout};

  function automatic stim_t idle();
    stim_t s;
    s.reset = 1'b0;
    s.sv = '0;
    for (int i = 0; i < 4; i++) begin
      s.rs[i]    = '0;
      s.rdata[i] = 32'h1000_0000 + 32'(i);
    end
    s.pmwk = 0; s.pwr = 0; s.pdst = 0; s.pcmp = 0; s.prd = 0; s.palu = 0; s.ppc4 = 0;
    s.qmwk = 0; s.qwr = 0; s.qdst = 0; s.qcmp = 0; s.qrd = 0; s.qalu = 0; s.qpc4 = 0; s.qdout = 0;
    return s;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_rd[2][4];
  bit          m_stall[2];
  bit          m_hold[2];
  int          m_cnt[2];
  bit          model_valid = 0;

  function automatic bit pre_hit(int i);
    return cur.pmwk && cur.pwr && cur.prd == cur.rs[i] && cur.rs[i] != 0;
  endfunction

  function automatic bit ppre_hit(int i);
    return cur.qmwk && cur.qwr && cur.qrd == cur.rs[i] && cur.rs[i] != 0;
  endfunction

  function automatic logic [31:0] value_of(logic [1:0] dst, logic [31:0] alu, logic [31:0] pc4,
                                           logic [1:0] cmp, logic [31:0] dout);
    if (dst == 2'b00) return alu;
    if (dst == 2'b01) return dout;
    if (dst == 2'b10) return pc4;
    return {31'd0, cmp[0]};
  endfunction

  function automatic logic [31:0] expected_operand(int i);
    if (pre_hit(i) && cur.pdst != 2'b01) return value_of(cur.pdst, cur.palu, cur.ppc4, cur.pcmp, 32'd0);
    if (ppre_hit(i)) return value_of(cur.qdst, cur.qalu, cur.qpc4, cur.qcmp, cur.qdout);
    return cur.rdata[i];
  endfunction

  task automatic model_edge(input int m, input int n, input int cmax);
    bit haz = 0;
    if (!m_hold[m])
      for (int i = 0; i < n; i++)
        if (cur.sv[i] && pre_hit(i) && cur.pdst == 2'b01) haz = 1;
    if (haz) begin
      m_stall[m] = 1;
      m_hold[m]  = 1;
      if (m_cnt[m] < cmax) m_cnt[m]++;
    end else begin
      for (int i = 0; i < n; i++) m_rd[m][i] = expected_operand(i);
      m_stall[m] = 0;
      m_hold[m]  = 0;
    end
  endtask

  always @(posedge CLK) begin
    if (cur.reset) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 4; i++) m_rd[m][i] = '0;
        m_stall[m] = 0; m_hold[m] = 0; m_cnt[m] = 0;
      end
      model_valid = 1;
    end else if (model_valid) begin
      model_edge(0, 2, 65535);
      model_edge(1, 3, 3);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Outputs are registered; compare on the falling edge.
  always @(negedge CLK) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) chk($sformatf("a_rd%0d", i), ifa.RD[i*32 +: 32], m_rd[0][i]);
      chk("a_stall", 32'(ifa.Stall), 32'(m_stall[0]));
      chk("a_cnt",   32'(ifa.StallCount), 32'(m_cnt[0]));
      chk("a_state", 32'(ifa.DbgState), 32'(m_hold[0] ? ST_HOLD : ST_RUN));
      for (int i = 0; i < 3; i++) chk($sformatf("b_rd%0d", i), ifb.RD[i*32 +: 32], m_rd[1][i]);
      chk("b_stall", 32'(ifb.Stall), 32'(m_stall[1]));
      chk("b_cnt",   32'(ifb.StallCount), 32'(m_cnt[1]));
      chk("b_state", 32'(ifb.DbgState), 32'(m_hold[1] ? ST_HOLD : ST_RUN));
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input stim_t s);
    cur = s;
    @(posedge CLK);
    #1;
  endtask

  function automatic stim_t load_use(logic [3:0] sv);
    stim_t s = idle();
    s.pmwk = 1; s.pwr = 1; s.pdst = 2'b01; s.prd = 5'd7; s.palu = 32'hDEAD_0000;
    s.rs[0] = 5'd7; s.sv = sv; s.rdata[0] = 32'h7777;
    return s;
  endfunction

  initial begin
    stim_t s;
    s = idle();
    s.reset = 1;
    cur = s;
    cycle(s);
    cycle(s);
    chk("lit_reset_rd",   ifa.RD[31:0], 32'h0);
    chk("lit_reset_stall", 32'(ifa.Stall), 32'h0);
    chk("lit_reset_cnt",  32'(ifa.StallCount), 32'h0);

    // pre priority over ppre, then x0 never forwarded
    s = idle();
    s.rs[0] = 5'd5;
    s.pmwk = 1; s.pwr = 1; s.pdst = 2'b00; s.prd = 5'd5; s.palu = 32'hAAAA;
    s.qmwk = 1; s.qwr = 1; s.qdst = 2'b00; s.qrd = 5'd5; s.qalu = 32'hBBBB;
    cycle(s);
    chk("lit_pre_priority", ifa.RD[31:0], 32'hAAAA);
    s.rs[0] = 5'd0; s.prd = 5'd0; s.qrd = 5'd0;
    cycle(s);
    chk("lit_x0_readdata", ifa.RD[31:0], 32'h1000_0000);

    // link value from pre, compare bit from ppre
    s = idle();
    s.pmwk = 1; s.pwr = 1; s.pdst = 2'b10; s.prd = 5'd1; s.ppc4 = 32'h104; s.palu = 32'h9999;
    s.rs[1] = 5'd1;
    cycle(s);
    chk("lit_pre_pc4", ifa.RD[63:32], 32'h104);
    s = idle();
    s.qmwk = 1; s.qwr = 1; s.qdst = 2'b11; s.qcmp = 2'b01; s.qrd = 5'd1;
    s.rs[1] = 5'd1; s.rdata[0] = 32'h5555;
    cycle(s);
    chk("lit_ppre_cmp", ifa.RD[63:32], 32'h1);
    chk("lit_rd0_plain", ifa.RD[31:0], 32'h5555);

    // load-use: one stall, then load data from ppre
    cycle(load_use(4'b0001));
    chk("lit_lu_stall", 32'(ifa.Stall), 32'h1);
    chk("lit_lu_hold_rd", ifa.RD[31:0], 32'h5555);
    chk("lit_lu_cnt", 32'(ifa.StallCount), 32'h1);
    s = idle();
    s.qmwk = 1; s.qwr = 1; s.qdst = 2'b01; s.qrd = 5'd7; s.qdout = 32'h1234; s.qalu = 32'h4321;
    s.rs[0] = 5'd7; s.sv = 4'b0001;
    cycle(s);
    chk("lit_lu_data", ifa.RD[31:0], 32'h1234);
    chk("lit_lu_release", 32'(ifa.Stall), 32'h0);

    // same load, operand not read -> no stall
    cycle(load_use(4'b0000));
    chk("lit_nv_stall", 32'(ifa.Stall), 32'h0);
    chk("lit_nv_cnt", 32'(ifa.StallCount), 32'h1);
    chk("lit_nv_rd", ifa.RD[31:0], 32'h7777);

    // hazard only on operand 2: stalls only the 3-operand build
    s = idle();
    s.pmwk = 1; s.pwr = 1; s.pdst = 2'b01; s.prd = 5'd9;
    s.rs[2] = 5'd9; s.sv = 4'b0100;
    cycle(s);
    chk("lit_rs2_a_stall", 32'(ifa.Stall), 32'h0);
    chk("lit_rs2_b_stall", 32'(ifb.Stall), 32'h1);
    cycle(idle());
    chk("lit_rs2_b_release", 32'(ifb.Stall), 32'h0);

    // reset while in HOLD, then a fresh hazard
    cycle(load_use(4'b0001));
    s = idle();
    s.reset = 1;
    cycle(s);
    chk("lit_midhold_rd", ifa.RD[31:0], 32'h0);
    chk("lit_midhold_stall", 32'(ifa.Stall), 32'h0);
    chk("lit_midhold_cnt", 32'(ifa.StallCount), 32'h0);
    chk("lit_midhold_state", 32'(ifa.DbgState), 32'(ST_RUN));
    cycle(load_use(4'b0001));
    chk("lit_fresh_stall", 32'(ifa.Stall), 32'h1);
    chk("lit_fresh_cnt", 32'(ifa.StallCount), 32'h1);
    cycle(idle());

    // five more hazard/hold pairs: 2-bit counter saturates
    for (int k = 0; k < 5; k++) begin
      cycle(load_use(4'b0001));
      cycle(idle());
    end
    chk("lit_sat_b_cnt", 32'(ifb.StallCount), 32'h3);
    chk("lit_sat_a_cnt", 32'(ifa.StallCount), 32'h6);

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
